// File: rtl/project_blastn_memory_access_mc_if.sv
// Memory-access bus for project_blastn_memory_access_mc: the memory message
// types, plus the UGPE write channels, the sequence-reader read port, the
// 4B memory port and the completion strobe.
// The master modport is the access unit and the slave modport is its environment.
package project_blastn_memory_access_mc_pkg;
   localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;
endpackage

interface project_blastn_memory_access_mc_if #(
   parameter int unsigned p_num_ugpe   = 4,
   parameter int unsigned p_num_fields = 4,
   parameter int unsigned p_field_bits = 8
) ();
   localparam int unsigned W  = p_num_fields * (32 + p_field_bits);
   localparam int unsigned CW = (p_num_ugpe > 1) ? $clog2(p_num_ugpe) : 1;

   logic [p_num_ugpe*W-1:0] ugpe_istream_msg;
   logic [p_num_ugpe-1:0]   ugpe_istream_val;
   logic [p_num_ugpe-1:0]   ugpe_istream_rdy;

   logic [31:0] sr_req_istream_msg;
   logic        sr_req_istream_val;
   logic        sr_req_istream_rdy;

   logic [31:0] sr_resp_istream_msg;
   logic        sr_resp_istream_val;
   logic        sr_resp_istream_rdy;

   project_blastn_memory_access_mc_pkg::mem_req_4B_t  mem_reqstream_msg;
   logic                                              mem_reqstream_val;
   logic                                              mem_reqstream_rdy;

   project_blastn_memory_access_mc_pkg::mem_resp_4B_t mem_respstream_msg;
   logic                                              mem_respstream_val;
   logic                                              mem_respstream_rdy;

   logic          done;
   logic [CW-1:0] done_chan;

   modport master (
      input  ugpe_istream_msg, ugpe_istream_val,
      output ugpe_istream_rdy,
      input  sr_req_istream_msg, sr_req_istream_val,
      output sr_req_istream_rdy,
      output sr_resp_istream_msg, sr_resp_istream_val,
      input  sr_resp_istream_rdy,
      output mem_reqstream_msg, mem_reqstream_val,
      input  mem_reqstream_rdy,
      input  mem_respstream_msg, mem_respstream_val,
      output mem_respstream_rdy,
      output done, done_chan
   );

   modport slave (
      output ugpe_istream_msg, ugpe_istream_val,
      input  ugpe_istream_rdy,
      output sr_req_istream_msg, sr_req_istream_val,
      input  sr_req_istream_rdy,
      input  sr_resp_istream_msg, sr_resp_istream_val,
      output sr_resp_istream_rdy,
      input  mem_reqstream_msg, mem_reqstream_val,
      output mem_reqstream_rdy,
      output mem_respstream_msg, mem_respstream_val,
      input  mem_respstream_rdy,
      input  done, done_chan
   );
endinterface

// File: rtl/project_blastn_memory_access_mc.sv
// BLASTN memory access unit: arbitrates a sequence-reader read port and
// p_num_ugpe UGPE result channels onto one 4B memory port. Each UGPE record
// is scattered as p_num_fields back-to-back word writes.
// Define PROJECT_BLASTN_MEMACC_RR_EN for round-robin UGPE arbitration;
// the default build uses fixed priority (lowest channel index wins).
module project_blastn_memory_access_mc
   import project_blastn_memory_access_mc_pkg::*;
#(
   parameter int unsigned p_num_ugpe   = 4,
   parameter int unsigned p_num_fields = 4,
   parameter int unsigned p_field_bits = 8
) (
   input logic clk,
   input logic reset,
   project_blastn_memory_access_mc_if.master bus
);
   localparam int unsigned W  = p_num_fields * (32 + p_field_bits);
   localparam int unsigned CW = (p_num_ugpe > 1) ? $clog2(p_num_ugpe) : 1;
   localparam int unsigned NW = $clog2(p_num_fields + 1);

   typedef enum logic [2:0] {IDLE, READ, RWAIT, SEND, WRITE, WDRAIN} state_t;

   state_t                state, state_next;
   logic [31:0]           rd_addr, rd_data;
   logic [W-1:0]          rec;
   logic [CW-1:0]         chan;
   logic [NW-1:0]         issue_cnt, resp_cnt;
   logic                  take_read, take_ugpe;
   logic                  q_full, deq_rdy, deq_fire;
   logic [31:0]           q_data;
   logic                  grant_any;
   logic [CW-1:0]         grant_idx;
   logic [p_num_ugpe-1:0] grant_onehot;
   logic [W-1:0]          grant_rec;
   logic [31:0]           field_addr, field_data;

   // 1-entry pipe queue: may accept while being drained, never bypasses
   assign bus.mem_respstream_rdy = !q_full || deq_rdy;
   assign deq_fire = q_full && deq_rdy;

   // Response queue storage
   always_ff @(posedge clk) begin
      if (reset) begin
         q_full <= 1'b0;
         q_data <= '0;
      end else if (bus.mem_respstream_val && bus.mem_respstream_rdy) begin
         q_full <= 1'b1;
         q_data <= bus.mem_respstream_msg.data;
      end else if (deq_fire) begin
         q_full <= 1'b0;
      end
   end

`ifdef PROJECT_BLASTN_MEMACC_RR_EN
   logic [CW-1:0] last;

   // Last-granted pointer; reset value makes channel 0 the first searched
   always_ff @(posedge clk) begin
      if (reset) last <= CW'(p_num_ugpe - 1);
      else if (take_ugpe) last <= grant_idx;
   end
`endif

   // UGPE channel selection and the selected record
   always_comb begin
      grant_any    = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      grant_rec    = '0;
`ifdef PROJECT_BLASTN_MEMACC_RR_EN
      for (int unsigned k = 1; k <= p_num_ugpe; k++)
         for (int unsigned c = 0; c < p_num_ugpe; c++)
            if (!grant_any && bus.ugpe_istream_val[c] &&
                ((32'(last) + k) % p_num_ugpe) == c) begin
               grant_any = 1'b1;
               grant_idx = CW'(c);
            end
`else
      for (int unsigned c = 0; c < p_num_ugpe; c++)
         if (!grant_any && bus.ugpe_istream_val[c]) begin
            grant_any = 1'b1;
            grant_idx = CW'(c);
         end
`endif
      for (int unsigned c = 0; c < p_num_ugpe; c++)
         if (grant_idx == CW'(c)) begin
            grant_onehot[c] = grant_any;
            grant_rec       = bus.ugpe_istream_msg[c*W +: W];
         end
   end

   // Address and zero-extended data of the field currently being issued
   always_comb begin
      field_addr = '0;
      field_data = '0;
      for (int unsigned i = 0; i < p_num_fields; i++)
         if (issue_cnt == NW'(i)) begin
            field_addr = rec[p_num_fields*p_field_bits + 32*i +: 32];
            field_data = 32'(rec[i*p_field_bits +: p_field_bits]);
         end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next state and all handshake outputs
   always_comb begin
      state_next              = state;
      take_read               = 1'b0;
      take_ugpe               = 1'b0;
      deq_rdy                 = 1'b0;
      bus.sr_req_istream_rdy  = 1'b0;
      bus.ugpe_istream_rdy    = '0;
      bus.sr_resp_istream_val = 1'b0;
      bus.sr_resp_istream_msg = '0;
      bus.mem_reqstream_val   = 1'b0;
      bus.mem_reqstream_msg   = '0;
      bus.done                = 1'b0;
      bus.done_chan           = '0;
      case (state)
         IDLE: if (!reset) begin
            if (bus.sr_req_istream_val) begin
               bus.sr_req_istream_rdy = 1'b1;
               take_read              = 1'b1;
               state_next             = READ;
            end else if (grant_any) begin
               bus.ugpe_istream_rdy = grant_onehot;
               take_ugpe            = 1'b1;
               state_next           = WRITE;
            end
         end
         READ: begin
            bus.mem_reqstream_val          = 1'b1;
            bus.mem_reqstream_msg.msg_type = MEM_TYPE_READ;
            bus.mem_reqstream_msg.addr     = rd_addr;
            if (bus.mem_reqstream_rdy) state_next = RWAIT;
         end
         RWAIT: begin
            deq_rdy = 1'b1;
            if (q_full) state_next = SEND;
         end
         SEND: begin
            bus.sr_resp_istream_val = 1'b1;
            bus.sr_resp_istream_msg = rd_data;
            if (bus.sr_resp_istream_rdy) state_next = IDLE;
         end
         WRITE: begin
            deq_rdy                        = 1'b1;
            bus.mem_reqstream_val          = 1'b1;
            bus.mem_reqstream_msg.msg_type = MEM_TYPE_WRITE;
            bus.mem_reqstream_msg.opaque   = 8'(issue_cnt);
            bus.mem_reqstream_msg.addr     = field_addr;
            bus.mem_reqstream_msg.data     = field_data;
            if (bus.mem_reqstream_rdy && issue_cnt == NW'(p_num_fields - 1))
               state_next = WDRAIN;
         end
         WDRAIN: begin
            deq_rdy = 1'b1;
            if (deq_fire && resp_cnt == NW'(p_num_fields - 1)) begin
               bus.done      = 1'b1;
               bus.done_chan = chan;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transaction datapath: latched request, read data and field counters
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr   <= '0;
         rd_data   <= '0;
         rec       <= '0;
         chan      <= '0;
         issue_cnt <= '0;
         resp_cnt  <= '0;
      end else begin
         if (take_read) rd_addr <= bus.sr_req_istream_msg;
         if (state == RWAIT && deq_fire) rd_data <= q_data;
         if (take_ugpe) begin
            rec       <= grant_rec;
            chan      <= grant_idx;
            issue_cnt <= '0;
            resp_cnt  <= '0;
         end else begin
            if (state == WRITE && bus.mem_reqstream_rdy) issue_cnt <= issue_cnt + 1'b1;
            if ((state == WRITE || state == WDRAIN) && deq_fire) resp_cnt <= resp_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_project_blastn_memory_access_mc.sv
// Directed bench for project_blastn_memory_access_mc: vector table of reads
// and writes plus hand-written contention, priority, backpressure/reset and
// narrow-parameter sequences.
module tb_project_blastn_memory_access_mc;
   import project_blastn_memory_access_mc_pkg::*;

   localparam int unsigned NU = 4, NF = 4, FB = 8;
   localparam int unsigned W  = NF * (32 + FB);

   typedef struct packed {
      logic             is_rd;
      logic [1:0]       chan;
      logic [31:0]      addr;
      logic [3:0]       stall;
      logic [3:0][7:0]  d;
      logic [3:0][31:0] a;
      logic [31:0]      exp_rd;
      logic [3:0]       exp_hold;
      logic [3:0][31:0] exp_data;
      logic [1:0]       exp_chan;
   } vec_t;

   typedef struct {
      int unsigned cyc;
      logic [2:0]  t;
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } rq_t;

   typedef struct {
      int unsigned cyc;
      logic [31:0] v;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc = 0;
   int n_chk = 0;
   int n_bad = 0;
   logic toggle_rdy = 1'b0;

   logic [31:0] mem [logic [31:0]];
   rq_t rqlog[$];
   rq_t rqlog2[$];
   ev_t dlog[$];
   ev_t dlog2[$];
   ev_t glog[$];
   ev_t rlog[$];

   always #5 clk = ~clk;

   project_blastn_memory_access_mc_if #(.p_num_ugpe(NU), .p_num_fields(NF), .p_field_bits(FB)) bus ();
   project_blastn_memory_access_mc #(.p_num_ugpe(NU), .p_num_fields(NF), .p_field_bits(FB)) dut (
      .clk(clk), .reset(reset), .bus(bus.master));

   project_blastn_memory_access_mc_if #(.p_num_ugpe(1), .p_num_fields(2), .p_field_bits(32)) bus2 ();
   project_blastn_memory_access_mc #(.p_num_ugpe(1), .p_num_fields(2), .p_field_bits(32)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.master));

   function automatic logic [31:0] rd_mem(input logic [31:0] addr);
      return mem.exists(addr) ? mem[addr] : 32'd0;
   endfunction

   function automatic logic [31:0] oh_idx(input logic [NU-1:0] oh);
      logic [31:0] r = 32'hFFFF_FFFF;
      for (int i = 0; i < NU; i++) if (oh[i]) r = 32'(i);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.mem_reqstream_rdy  = toggle_rdy ? cyc[0] : 1'b1;
   assign bus2.mem_reqstream_rdy = 1'b1;

   // zero-wait memory model for the main instance, plus event logs
   always @(posedge clk) begin
      if (reset) begin
         bus.mem_respstream_val <= 1'b0;
         bus.mem_respstream_msg <= '0;
      end else begin
         if (bus.mem_respstream_val && bus.mem_respstream_rdy) bus.mem_respstream_val <= 1'b0;
         if (bus.mem_reqstream_val && bus.mem_reqstream_rdy) begin
            bus.mem_respstream_val <= 1'b1;
            bus.mem_respstream_msg <= mem_resp_4B_t'{bus.mem_reqstream_msg.msg_type,
               bus.mem_reqstream_msg.opaque, 2'd0,
               (bus.mem_reqstream_msg.msg_type == MEM_TYPE_READ) ? rd_mem(bus.mem_reqstream_msg.addr) : 32'd0};
         end
      end
      if (bus.mem_reqstream_val && bus.mem_reqstream_rdy)
         rqlog.push_back(rq_t'{cyc, bus.mem_reqstream_msg.msg_type, bus.mem_reqstream_msg.opaque,
                               bus.mem_reqstream_msg.addr, bus.mem_reqstream_msg.data});
      if (bus.done) dlog.push_back(ev_t'{cyc, 32'(bus.done_chan)});
      if (|(bus.ugpe_istream_rdy & bus.ugpe_istream_val))
         glog.push_back(ev_t'{cyc, oh_idx(bus.ugpe_istream_rdy & bus.ugpe_istream_val)});
      if (bus.sr_resp_istream_val && bus.sr_resp_istream_rdy)
         rlog.push_back(ev_t'{cyc, bus.sr_resp_istream_msg});
   end

   // zero-wait memory model for the narrow instance
   always @(posedge clk) begin
      if (reset) begin
         bus2.mem_respstream_val <= 1'b0;
         bus2.mem_respstream_msg <= '0;
      end else begin
         if (bus2.mem_respstream_val && bus2.mem_respstream_rdy) bus2.mem_respstream_val <= 1'b0;
         if (bus2.mem_reqstream_val && bus2.mem_reqstream_rdy) begin
            bus2.mem_respstream_val <= 1'b1;
            bus2.mem_respstream_msg <= mem_resp_4B_t'{bus2.mem_reqstream_msg.msg_type,
               bus2.mem_reqstream_msg.opaque, 2'd0, 32'd0};
         end
      end
      if (bus2.mem_reqstream_val && bus2.mem_reqstream_rdy)
         rqlog2.push_back(rq_t'{cyc, bus2.mem_reqstream_msg.msg_type, bus2.mem_reqstream_msg.opaque,
                                bus2.mem_reqstream_msg.addr, bus2.mem_reqstream_msg.data});
      if (bus2.done) dlog2.push_back(ev_t'{cyc, 32'(bus2.done_chan)});
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ugpe_rdy"}, 64'(bus.ugpe_istream_rdy), 0);
      chk({tag, "_sr_req_rdy"}, 64'(bus.sr_req_istream_rdy), 0);
      chk({tag, "_sr_resp_val"}, 64'(bus.sr_resp_istream_val), 0);
      chk({tag, "_sr_resp_msg"}, 64'(bus.sr_resp_istream_msg), 0);
      chk({tag, "_mem_req_val"}, 64'(bus.mem_reqstream_val), 0);
      chk({tag, "_mem_req_msg"}, 64'(bus.mem_reqstream_msg), 0);
      chk({tag, "_mem_resp_rdy"}, 64'(bus.mem_respstream_rdy), 1);
      chk({tag, "_done"}, 64'(bus.done), 0);
      chk({tag, "_done_chan"}, 64'(bus.done_chan), 0);
   endtask

   task automatic load_rec(input int c, input logic [3:0][7:0] d, input logic [3:0][31:0] a);
      for (int i = 0; i < NF; i++) begin
         bus.ugpe_istream_msg[c*W + i*FB +: FB]           = d[i];
         bus.ugpe_istream_msg[c*W + NF*FB + 32*i +: 32] = a[i];
      end
   endtask

   function automatic vec_t mk_rd(input logic [31:0] addr, input logic [3:0] stall,
                                  input logic [31:0] exp_rd, input logic [3:0] exp_hold);
      vec_t v = '0;
      v.is_rd = 1'b1; v.addr = addr; v.stall = stall; v.exp_rd = exp_rd; v.exp_hold = exp_hold;
      return v;
   endfunction

   function automatic vec_t mk_wr(input logic [1:0] ch, input logic [3:0][7:0] d, input logic [3:0][31:0] a,
                                  input logic [3:0][31:0] ed, input logic [1:0] ec);
      vec_t v = '0;
      v.chan = ch; v.d = d; v.a = a; v.exp_data = ed; v.exp_chan = ec;
      return v;
   endfunction

   task automatic do_read(input vec_t v);
      int unsigned t0, n, hold;
      int r0 = rqlog.size();
      @(negedge clk);
      bus.sr_req_istream_msg = v.addr; bus.sr_req_istream_val = 1'b1; bus.sr_resp_istream_rdy = 1'b0;
      #1 chk("rd_req_rdy", 64'(bus.sr_req_istream_rdy), 1);
      t0 = cyc;
      @(negedge clk);
      bus.sr_req_istream_val = 1'b0; bus.sr_req_istream_msg = '0;
      n = 0;
      while (!bus.sr_resp_istream_val && n < 20) begin @(negedge clk); n++; end
      chk("rd_resp_seen", 64'(bus.sr_resp_istream_val), 1);
      chk("rd_latency", 64'(cyc - t0), 4);
      chk("rd_mem_req_cnt", 64'(rqlog.size() - r0), 1);
      if (rqlog.size() > r0) begin
         chk("rd_mem_req_type", 64'(rqlog[r0].t), 64'(MEM_TYPE_READ));
         chk("rd_mem_req_addr", 64'(rqlog[r0].addr), 64'(v.addr));
         chk("rd_mem_req_data", 64'(rqlog[r0].data), 0);
         chk("rd_mem_req_lat", 64'(rqlog[r0].cyc - t0), 1);
      end
      hold = 0;
      for (int k = 0; k < int'(v.stall); k++) begin
         if (bus.sr_resp_istream_val) hold++;
         chk("rd_hold_msg", 64'(bus.sr_resp_istream_msg), 64'(v.exp_rd));
         @(negedge clk);
      end
      if (bus.sr_resp_istream_val) hold++;
      chk("rd_last_msg", 64'(bus.sr_resp_istream_msg), 64'(v.exp_rd));
      bus.sr_resp_istream_rdy = 1'b1;
      @(negedge clk);
      bus.sr_resp_istream_rdy = 1'b0;
      #1 chk("rd_hold_cycles", 64'(hold), 64'(v.exp_hold));
      chk("rd_back_idle", 64'(bus.sr_resp_istream_val), 0);
   endtask

   task automatic do_write(input vec_t v, input bit strict);
      int unsigned t0, n;
      int w0 = rqlog.size();
      int d0 = dlog.size();
      @(negedge clk);
      load_rec(int'(v.chan), v.d, v.a);
      bus.ugpe_istream_val = NU'(1) << v.chan;
      #1 chk("wr_grant", 64'(bus.ugpe_istream_rdy), 64'(NU'(1) << v.exp_chan));
      t0 = cyc;
      @(negedge clk);
      bus.ugpe_istream_val = '0; bus.ugpe_istream_msg = '0;
      n = 0;
      while (dlog.size() == d0 && n < 60) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("wr_done_pulses", 64'(dlog.size() - d0), 1);
      chk("wr_req_cnt", 64'(rqlog.size() - w0), 4);
      if (dlog.size() > d0) begin
         chk("wr_done_chan", 64'(dlog[d0].v), 64'(v.exp_chan));
         if (strict) chk("wr_done_lat", 64'(dlog[d0].cyc - t0), 6);
      end
      for (int i = 0; i < 4 && w0 + i < rqlog.size(); i++) begin
         chk("wr_type", 64'(rqlog[w0+i].t), 64'(MEM_TYPE_WRITE));
         chk("wr_opaque", 64'(rqlog[w0+i].op), 64'(i));
         chk("wr_addr", 64'(rqlog[w0+i].addr), 64'(v.a[i]));
         chk("wr_data", 64'(rqlog[w0+i].data), 64'(v.exp_data[i]));
         if (strict) chk("wr_issue_cyc", 64'(rqlog[w0+i].cyc - t0), 64'(i + 1));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int unsigned exp_g[5];
      int unsigned n;
      int d0, g0, w0, r0;

      bus.ugpe_istream_msg = '0; bus.ugpe_istream_val = '0;
      bus.sr_req_istream_msg = '0; bus.sr_req_istream_val = 1'b0; bus.sr_resp_istream_rdy = 1'b0;
      bus2.ugpe_istream_msg = '0; bus2.ugpe_istream_val = '0;
      bus2.sr_req_istream_msg = '0; bus2.sr_req_istream_val = 1'b0; bus2.sr_resp_istream_rdy = 1'b0;
      mem[32'h1000] = 32'hDEAD_BEEF;
      mem[32'h2000] = 32'h0000_0001;

      vt[0] = mk_rd(32'h1000, 4'd3, 32'hDEAD_BEEF, 4'd4);
      vt[1] = mk_wr(2'd2, {8'h44, 8'h33, 8'h22, 8'h11}, {32'h10C, 32'h108, 32'h104, 32'h100},
                    {32'h44, 32'h33, 32'h22, 32'h11}, 2'd2);
      vt[2] = mk_rd(32'h2000, 4'd0, 32'h0000_0001, 4'd1);
      vt[3] = mk_wr(2'd3, {8'h7F, 8'h80, 8'h00, 8'hFF}, {32'h1234_5678, 32'h8000_0000, 32'h0, 32'hFFFF_FFFC},
                    {32'h7F, 32'h80, 32'h00, 32'hFF}, 2'd3);
      vt[4] = mk_wr(2'd0, {8'hA5, 8'h5A, 8'hC3, 8'h3C}, {32'h20C, 32'h208, 32'h204, 32'h200},
                    {32'hA5, 32'h5A, 32'hC3, 32'h3C}, 2'd0);
      vt[5] = mk_wr(2'd1, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, {32'h30C, 32'h308, 32'h304, 32'h300},
                    {32'hDE, 32'hAD, 32'hBE, 32'hEF}, 2'd1);
`ifdef PROJECT_BLASTN_MEMACC_RR_EN
      exp_g = '{0, 1, 2, 3, 0};
`else
      exp_g = '{0, 0, 0, 0, 0};
`endif

      // reset state, during and one cycle after reset
      repeat (3) @(negedge clk);
      #1 chk_idle("rst");
      chk("rst2_mem_req_val", 64'(bus2.mem_reqstream_val), 0);
      chk("rst2_mem_resp_rdy", 64'(bus2.mem_respstream_rdy), 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1 chk_idle("post_rst");

      for (int i = 0; i < 6; i++) begin
         if (vt[i].is_rd) do_read(vt[i]);
         else             do_write(vt[i], 1'b1);
      end

      // contention: all channels valid continuously
      g0 = glog.size(); d0 = dlog.size();
      @(negedge clk);
      for (int c = 0; c < NU; c++) load_rec(c, {4{8'(c + 1)}}, {32'h40C, 32'h408, 32'h404, 32'h400});
      bus.ugpe_istream_val = '1;
      n = 0;
      while (glog.size() - g0 < 5 && n < 200) begin @(negedge clk); n++; end
      bus.ugpe_istream_val = '0;
      n = 0;
      while (dlog.size() - d0 < 5 && n < 60) begin @(negedge clk); n++; end
      bus.ugpe_istream_msg = '0;
      chk("cont_grants", 64'(glog.size() - g0), 5);
      chk("cont_dones", 64'(dlog.size() - d0), 5);
      for (int i = 0; i < 5 && g0 + i < glog.size(); i++) begin
         chk("cont_order", 64'(glog[g0+i].v), 64'(exp_g[i]));
         if (d0 + i < dlog.size()) chk("cont_done_chan", 64'(dlog[d0+i].v), 64'(exp_g[i]));
      end

      // read and channel 1 request in the same IDLE cycle
      g0 = glog.size(); d0 = dlog.size(); r0 = rlog.size();
      @(negedge clk);
      bus.sr_req_istream_msg = 32'h1000; bus.sr_req_istream_val = 1'b1; bus.sr_resp_istream_rdy = 1'b1;
      load_rec(1, {8'h04, 8'h03, 8'h02, 8'h01}, {32'h50C, 32'h508, 32'h504, 32'h500});
      bus.ugpe_istream_val = 4'b0010;
      #1 chk("prio_sr_rdy", 64'(bus.sr_req_istream_rdy), 1);
      chk("prio_ugpe_rdy", 64'(bus.ugpe_istream_rdy), 0);
      @(negedge clk);
      bus.sr_req_istream_val = 1'b0;
      n = 0;
      while (glog.size() == g0 && n < 40) begin @(negedge clk); n++; end
      bus.ugpe_istream_val = '0;
      n = 0;
      while (dlog.size() == d0 && n < 40) begin @(negedge clk); n++; end
      bus.sr_resp_istream_rdy = 1'b0; bus.ugpe_istream_msg = '0;
      chk("prio_rd_done", 64'(rlog.size() - r0), 1);
      chk("prio_grant", 64'(glog.size() - g0), 1);
      if (rlog.size() > r0 && glog.size() > g0) begin
         chk("prio_rd_data", 64'(rlog[r0].v), 64'h0000_0000_DEAD_BEEF);
         chk("prio_grant_chan", 64'(glog[g0].v), 1);
         chk("prio_order", 64'(glog[g0].cyc > rlog[r0].cyc), 1);
      end
      chk("prio_done", 64'(dlog.size() - d0), 1);
      if (dlog.size() > d0) chk("prio_done_chan", 64'(dlog[d0].v), 1);

      // request backpressure toggling 1010...
      toggle_rdy = 1'b1;
      do_write(vt[1], 1'b0);
      toggle_rdy = 1'b0;

      // reset after the second write request
      w0 = rqlog.size(); d0 = dlog.size();
      @(negedge clk);
      load_rec(1, {8'h04, 8'h03, 8'h02, 8'h01}, {32'h60C, 32'h608, 32'h604, 32'h600});
      bus.ugpe_istream_val = 4'b0010;
      @(negedge clk);
      bus.ugpe_istream_val = '0; bus.ugpe_istream_msg = '0;
      n = 0;
      while (rqlog.size() - w0 < 2 && n < 20) begin @(negedge clk); n++; end
      chk("rst_mid_reqs", 64'(rqlog.size() - w0), 2);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk_idle("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1 chk_idle("rst_mid_after");
      repeat (10) @(negedge clk);
      chk("rst_mid_no_done", 64'(dlog.size() - d0), 0);
      do_write(vt[1], 1'b1);

      // narrow configuration: one channel, two 32-bit fields
      @(negedge clk);
      bus2.ugpe_istream_msg = {32'h0000_0044, 32'h0000_0040, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      bus2.ugpe_istream_val = 1'b1;
      #1 chk("nar_grant", 64'(bus2.ugpe_istream_rdy), 1);
      @(negedge clk);
      bus2.ugpe_istream_val = 1'b0;
      n = 0;
      while (dlog2.size() == 0 && n < 40) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("nar_dones", 64'(dlog2.size()), 1);
      if (dlog2.size() > 0) chk("nar_done_chan", 64'(dlog2[0].v), 0);
      chk("nar_reqs", 64'(rqlog2.size()), 2);
      if (rqlog2.size() >= 2) begin
         chk("nar_addr0", 64'(rqlog2[0].addr), 64'h40);
         chk("nar_addr1", 64'(rqlog2[1].addr), 64'h44);
         chk("nar_data0", 64'(rqlog2[0].data), 64'hFFFF_FFFF);
         chk("nar_data1", 64'(rqlog2[1].data), 64'hFFFF_FFFF);
         chk("nar_op1", 64'(rqlog2[1].op), 1);
         chk("nar_consec", 64'(rqlog2[1].cyc - rqlog2[0].cyc), 1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/project_blastn_memory_access_mc.md
# project_blastn_memory_access_mc

Multi-channel, parametrised memory access unit for the BLASTN accelerator. It arbitrates a sequence-reader read port and `p_num_ugpe` ungapped-extension (UGPE) result write channels onto a single 4B memory request/response port. Each UGPE result record is scattered to memory as `p_num_fields` word writes, issued back-to-back with responses counted concurrently. It sits between the UGPE array / sequence reader and the memory port.

## Interface
- `p_num_ugpe`, default 4: number of UGPE write channels (1..8).
- `p_num_fields`, default 4: fields per UGPE record.
- `p_field_bits`, default 8: width of each field value (1..32).
- Record width `W = p_num_fields*(32+p_field_bits)`.
  - Data field i is at `[i*p_field_bits +: p_field_bits]`.
  - Address i is at `[p_num_fields*p_field_bits + 32*i +: 32]`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ugpe_istream_msg` in `p_num_ugpe*W`: per-channel records; channel c at `[c*W +: W]`.
- `ugpe_istream_val` in `p_num_ugpe`: per-channel valid.
- `ugpe_istream_rdy` out `p_num_ugpe`: per-channel ready, one-hot or zero.
- `sr_req_istream_msg` in 32: read address.
- `sr_req_istream_val` in 1, `sr_req_istream_rdy` out 1: read-request handshake.
- `sr_resp_istream_msg` out 32: read data.
- `sr_resp_istream_val` out 1, `sr_resp_istream_rdy` in 1: read-response handshake.
- `mem_reqstream_msg` out `mem_req_4B_t`, `mem_reqstream_val` out 1, `mem_reqstream_rdy` in 1: memory request.
- `mem_respstream_msg` in `mem_resp_4B_t`, `mem_respstream_val` in 1, `mem_respstream_rdy` out 1: memory response, buffered by a 1-entry pipe queue.
- `done` out 1: one-cycle pulse when a record's last write response is consumed.
- `done_chan` out `$clog2(p_num_ugpe)` (min 1): channel of the completed record; valid only while `done` is high.

## Operation
- States: IDLE, READ, RWAIT, SEND, WRITE, WDRAIN.
- IDLE:
  - A pending `sr_req_istream_val` has priority: assert `sr_req_istream_rdy`, latch the address, go to READ.
  - Otherwise, if any `ugpe_istream_val` is high, grant exactly one channel (see Configuration): assert its rdy, latch its record and channel index, clear the issue/response counters, go to WRITE.
- READ:
  - Drive `mem_reqstream_val`=1 with type READ, opaque 0, len 0, data 0, addr = latched address.
  - On `mem_reqstream_rdy`, go to RWAIT.
- RWAIT: `memresp_deq_rdy`=1; on a valid response, latch its data and go to SEND.
- SEND:
  - Drive `sr_resp_istream_val`=1 with the latched data.
  - Hold val and msg stable until `sr_resp_istream_rdy`, then go to IDLE.
- WRITE:
  - Drive `mem_reqstream_val`=1 with type WRITE, len 0, opaque = issue index, addr = address[issue index], data = zero-extended field[issue index].
  - Increment the issue counter on each accepted request.
  - `memresp_deq_rdy`=1 throughout; increment the response counter on each consumed response, which may coincide with an issue.
  - After field `p_num_fields-1` is accepted, go to WDRAIN.
- WDRAIN:
  - `memresp_deq_rdy`=1.
  - When a consumed response makes the response count equal `p_num_fields`, pulse `done` with `done_chan` in the same cycle and go to IDLE.
- Counters are `$clog2(p_num_fields+1)` bits wide and never wrap.
- Response order is in-order, so opaque is informational only.
- `mem_reqstream_msg` is forced to all-zero whenever `mem_reqstream_val`=0.
- Write responses arriving in IDLE/READ/SEND are not dequeued; the memory model must not produce them.

## Timing
- While `reset` is high, and in the cycle after it deasserts: state is IDLE and every output is 0 except `mem_respstream_rdy`, which is 1 (empty queue).
  - The response queue is flushed on reset.
  - Reset mid-transaction abandons it silently, with no `done` pulse.
- Input rdy signals are combinational in IDLE only; an accepted transaction's memory request appears the next cycle.
- Read latency with zero-wait memory and sink: request accepted at cycle T, mem req at T+1, response into queue at T+2, dequeued T+3, `sr_resp_istream_val` at T+4.
- Write: with `mem_reqstream_rdy` held high, field requests go out on consecutive cycles (1 per cycle). `done` pulses the cycle the final response is dequeued.
- A read request and a UGPE request in the same IDLE cycle: the read wins; the UGPE request waits.
- A new transaction never starts in the cycle `done` pulses (the FSM is in WDRAIN).

## Configuration
- `PROJECT_BLASTN_MEMACC_RR_EN` defined: round-robin among UGPE channels.
  - Search starts at (last granted + 1) mod `p_num_ugpe`.
  - The last-granted pointer resets to `p_num_ugpe-1`, so channel 0 is searched first.
  - The pointer updates only on a grant.
- Undefined: fixed priority, lowest asserted channel index wins, no pointer state.

## Test plan
- Read: `sr_req` addr 0x1000, memory word 0xDEADBEEF, `sr_resp_istream_rdy` low 3 cycles → resp val held for 4 cycles with msg 0xDEADBEEF, then IDLE.
- Single write, defaults: channel 2, data fields {0x11,0x22,0x33,0x44}, addresses {0x100,0x104,0x108,0x10C} → four WRITE requests on consecutive cycles with opaque 0..3 and data 0x00000011..0x00000044; one `done` pulse with `done_chan`=2.
- Contention: all 4 channels valid continuously.
  - With RR_EN: grant order 0,1,2,3,0.
  - Without RR_EN: channel 0 every time.
- Read priority: `sr_req_val` and `ugpe_val[1]` both rise in the same IDLE cycle → read completes first, then channel 1 writes.
- Backpressure/reset: `mem_reqstream_rdy` toggling 1010… during a write gives exactly 4 requests, no duplicates. Reset asserted after the 2nd request gives no `done` and all outputs 0; the next transaction proceeds normally.
- Parameter sweep: `p_num_ugpe`=1, `p_num_fields`=2, `p_field_bits`=32, data 0xFFFFFFFF → two full-width writes, `done_chan`=0.
